// File: rtl/splat_pkg.sv
// Shared types for the splat stream path: the 32-byte splat_2d_t record and its unpack helper.
package splat_pkg;

    localparam int SPLAT_BYTES = 32;
    localparam int SPLAT_BITS  = 256;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} unp_state_t;

    // Declared MSB-first, so sx occupies byte 0 and bbox_y1 bytes 30-31.
    typedef struct packed {
        logic signed [15:0] bbox_y1;
        logic signed [15:0] bbox_x1;
        logic signed [15:0] bbox_y0;
        logic signed [15:0] bbox_x0;
        logic [7:0]         opacity;
        logic [7:0]         b;
        logic [7:0]         g;
        logic [7:0]         r;
        logic signed [31:0] cov_b2;
        logic [15:0]        cov_c;
        logic [15:0]        cov_a;
        logic [31:0]        depth;
        logic signed [31:0] sy;
        logic signed [31:0] sx;
    } splat_2d_t;

    function automatic splat_2d_t splat_unpack(input logic [SPLAT_BITS-1:0] raw);
        splat_2d_t s;
        s.sx      = raw[31:0];
        s.sy      = raw[63:32];
        s.depth   = raw[95:64];
        s.cov_a   = raw[111:96];
        s.cov_c   = raw[127:112];
        s.cov_b2  = raw[159:128];
        s.r       = raw[167:160];
        s.g       = raw[175:168];
        s.b       = raw[183:176];
        s.opacity = raw[191:184];
        s.bbox_x0 = raw[207:192];
        s.bbox_y0 = raw[223:208];
        s.bbox_x1 = raw[239:224];
        s.bbox_y1 = raw[255:240];
        return s;
    endfunction

endpackage

// File: rtl/splat_word_assembler.sv
// Gathers BUS_W-bit words into a 256-bit record; the completed record bypasses the final slot
// so the top level can capture it on the same edge the last word is accepted.
module splat_word_assembler
    import splat_pkg::*;
#(
    parameter int BUS_W = 64,
    localparam int WPS = SPLAT_BITS / BUS_W,
    localparam int IDX_W = (WPS > 1) ? $clog2(WPS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  word_accept,
    input  logic [BUS_W-1:0]      word_data,
    output logic                  last_slot,
    output logic                  record_done,
    output logic [SPLAT_BITS-1:0] record
);

    localparam int LAST_LO = (WPS - 1) * BUS_W;

    logic [SPLAT_BITS-1:0] slots;
    logic [IDX_W-1:0]      word_idx;

    assign last_slot   = (word_idx == IDX_W'(WPS - 1));
    assign record_done = word_accept && last_slot;

    always_comb begin
        record = slots;
        record[LAST_LO +: BUS_W] = word_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slots    <= '0;
            word_idx <= '0;
        end else if (clear) begin
            word_idx <= '0;
        end else if (word_accept) begin
            for (int k = 0; k < WPS; k++) begin
                if (word_idx == IDX_W'(k))
                    slots[k*BUS_W +: BUS_W] <= word_data;
            end
            word_idx <= last_slot ? '0 : word_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/splat_stream_unpacker.sv
// Streams a run of splat_2d_t records out of DDR3 read words, with a one-record output buffer
// so assembly of the next record overlaps a consumer stall.
module splat_stream_unpacker
    import splat_pkg::*;
#(
    parameter int BUS_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] splat_count,
    input  logic             abort,
    input  logic [BUS_W-1:0] word_data,
    input  logic             word_valid,
    output logic             word_ready,
    output splat_2d_t        out_splat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    unp_state_t            state;
    logic [CNT_W-1:0]      fetch_cnt;
    logic                  done_r;
    logic                  last_slot;
    logic                  record_done;
    logic [SPLAT_BITS-1:0] record;
    logic                  word_accept;
    logic                  xfer;
    logic                  final_xfer;

    // Only the completing slot must wait for the output buffer to free up.
    assign word_ready  = (state == ST_FILL) && (!last_slot || !out_valid || out_ready);
    assign word_accept = word_valid && word_ready;
    assign xfer        = out_valid && out_ready;
    assign final_xfer  = xfer && (state == ST_DRAIN) && (remaining == CNT_W'(1)) && !abort;
    assign busy        = (state != ST_IDLE);
    assign done        = done_r || final_xfer;

    splat_word_assembler #(.BUS_W(BUS_W)) u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear       (abort || (state == ST_IDLE && start)),
        .word_accept (word_accept),
        .word_data   (word_data),
        .last_slot   (last_slot),
        .record_done (record_done),
        .record      (record)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            fetch_cnt <= '0;
            remaining <= '0;
            out_splat <= '0;
            out_valid <= 1'b0;
            done_r    <= 1'b0;
        end else if (abort) begin
            state     <= ST_IDLE;
            fetch_cnt <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (record_done) begin
                out_splat <= splat_unpack(record);
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (xfer)
                remaining <= remaining - CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (splat_count != '0) begin
                            remaining <= splat_count;
                            fetch_cnt <= splat_count;
                            state     <= ST_FILL;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (record_done) begin
                        fetch_cnt <= fetch_cnt - CNT_W'(1);
                        if (fetch_cnt == CNT_W'(1))
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (final_xfer)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/splat_stream_unpacker.md
# splat_stream_unpacker

Parametrised successor to the single-shot splat reader. It accepts a stream of BUS_W-bit DDR3 read words and assembles a run of N consecutive 32-byte `splat_2d_t` records. Each completed record is emitted on a valid/ready output with one-record buffering, so word fetch overlaps consumer stalls. It sits between the DDR3 read-burst engine and the tile rasteriser's splat setup stage.

## Interface
- `BUS_W`, 64, input word width; legal values 64, 128, 256; WPS = 256/BUS_W words per splat.
- `CNT_W`, 16, width of the splat-count and remaining-count registers.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  pulse; begin a run of `splat_count` splats. Ignored while `busy`=1.
- `splat_count`  in  CNT_W  number of splats in the run; sampled on an accepted `start`.
- `abort`  in  1  synchronous flush of the current run.
- `word_data`  in  BUS_W  little-endian slice of the record stream.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  word accepted when `word_valid && word_ready`.
- `out_splat`  out  256 (`splat_2d_t`)  unpacked record, all fields including raw `depth`.
- `out_valid`  out  1  `out_splat` holds a complete record.
- `out_ready`  in  1  consumer accepts; transfer happens when `out_valid && out_ready`.
- `busy`  out  1  a run is in progress (FILL or DRAIN).
- `done`  out  1  one-cycle pulse when the last splat of a run is transferred.
- `remaining`  out  CNT_W  splats of the run not yet transferred on the output.

## Operation
- States:
  - IDLE
  - FILL: gathering words.
  - DRAIN: every splat has been assembled and the last one is waiting on the output.
- IDLE + `start`:
  - `splat_count`≠0: latch the count into `remaining` and into a fetch counter, clear the word index, go to FILL.
  - `splat_count`=0: pulse `done` the next cycle, stay IDLE, consume no words.
- FILL:
  - Each accepted word is written into slot `word_idx` of the 256-bit assembly register. Slot k covers bits [k*BUS_W +: BUS_W]. `word_idx` then increments, mod WPS.
  - Accepting slot WPS-1 completes a record. The assembly register is copied into the output register, `out_valid` is set and the fetch counter decrements.
  - When the fetch counter reaches 0, go to DRAIN.
- `word_ready` = (state==FILL) && (word_idx≠WPS-1 || !out_valid || out_ready). Non-final slots always fill, so assembly of splat k+1 overlaps the output stall of splat k.
- Output transfer: `remaining` decrements. On the transfer where `remaining`==1, `done` pulses the same cycle, `busy` drops the next cycle and the state returns to IDLE.
- Field mapping is the fixed `splat_2d_t` layout (bytes 0-31):
  - sx, sy: s14.4.
  - depth: f32, passed through.
  - cov_a, cov_c: u2.14.
  - cov_b2: s2.14, 32-bit.
  - r, g, b, opacity: 8 bits each.
  - bbox x0, y0, x1, y1: s16.
- `abort` has priority over every other event in the same cycle. It discards the partial record and the buffered output, and clears `out_valid`, `word_ready` and `busy`. No `done` pulse. It returns to IDLE the next cycle.
- `start` and the final output transfer in the same cycle: the run still completes, and `start` is ignored because `busy`=1 in that cycle.
- `reset` mid-run behaves like `abort` and additionally zeroes all registers.

## Timing
- Reset values:
  - `word_ready`, `out_valid`, `busy`, `done`: 0.
  - `out_splat`, `remaining`: 0.
  - State: IDLE.
- `word_ready` is first asserted in the cycle after an accepted `start`.
- Latency: final word accepted in cycle t → `out_valid`=1 in cycle t+1.
- Throughput: sustains 1 word/cycle (one splat per WPS cycles) with `out_ready` held high. There are no bubbles between splats.
- `out_splat` is stable while `out_valid && !out_ready`.
- `word_ready` is a combinational function of registered state and `out_ready` only. It never depends on `word_valid`.

## Structure
- Package `splat_pkg`:
  - `splat_2d_t` packed struct, with the fields listed under Operation.
  - `SPLAT_BYTES`=32 and `SPLAT_BITS`=256.
  - Function `splat_unpack(logic [255:0])` returning `splat_2d_t`.
- Sub-module `splat_word_assembler #(BUS_W)`. It holds the slot register, `word_idx` and completion detection, and outputs a `record_done` strobe plus the 256-bit record. The top level holds the FSM, counters and output register.

## Test plan
- **BUS_W=64, count=1.** Send 4 words encoding sx=0x00000140, sy=-32, cov_a=0x4000, cov_c=0x2000, cov_b2=-0x100, rgba=10/20/30/255, bbox=(-4,2,60,33).
  - Expect all fields exact.
  - Expect `out_valid` 1 cycle after word 3, `done` on transfer, then `busy`=0.
- **BUS_W=128, count=3, word_valid and out_ready held high.**
  - Expect 3 splats on cycles t+2, t+4, t+6 with no gaps.
  - Expect `remaining` 3→0 and a single `done`.
- **BUS_W=64, count=2, out_ready=0 for 10 cycles after splat 0 is presented.**
  - Expect splat 1 slots 0-2 accepted, `word_ready`=0 at slot 3, splat 0 held stable.
  - After release, expect splat 1 one cycle later.
- **count=0.** Expect `done` 1 cycle after `start`, no words consumed, `busy` stays 0.
- **abort after word 2 of splat 1 (count=4), then start with count=1.**
  - Expect no `done` and `out_valid` cleared.
  - Expect the new run to assemble from slot 0 correctly.
- **start pulsed during FILL with splat_count=9, plus random word_valid gaps.**
  - Expect the start ignored, the original count delivered, and fields bit-exact against the model.
